// File: rtl/openram_tc_pkg.sv
// Shared types and constants for the openram test-chip scan host.
// The state enum and packet field offsets are common to the host RTL and its users.
package openram_tc_pkg;

  localparam int unsigned PKT_W_DEFAULT = 112;

  // Command packet field positions (LSB of each field) within the scan chain
  localparam int unsigned ADDR0_LSB  = 96;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DIN0_LSB   = 64;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CSB0_BIT   = 63;
  localparam int unsigned WEB0_BIT   = 62;
  localparam int unsigned WMASK0_LSB = 58;
  localparam int unsigned WMASK_W    = 4;
  localparam int unsigned ADDR1_LSB  = 42;
  localparam int unsigned CSB1_BIT   = 41;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    LOAD      = 3'd2,
    WAIT      = 3'd3,
    SHIFT_OUT = 3'd4,
    DONE      = 3'd5
  } scan_state_e;

endpackage

// File: rtl/scan_clk_gen.sv
// Scan clock divider: low for DIV clk cycles, then high for DIV cycles, while run is set.
// Held low with the phase counter at zero whenever run is clear.
module scan_clk_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  output logic scan_clk,
  output logic tick_fall,
  output logic tick_sample
);

  localparam int unsigned CW = $clog2(2 * DIV);
  localparam logic [CW-1:0] LAST       = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] HIGH_START = CW'(DIV);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  assign cnt_next  = (cnt == LAST) ? '0 : cnt + 1'b1;
  assign tick_fall = run && (cnt == LAST);
  // The last high cycle is also the cycle whose closing edge drops scan_clk.
  assign tick_sample = run && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn || !run) begin
      cnt      <= '0;
      scan_clk <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      scan_clk <= (cnt_next >= HIGH_START);
    end
  end

endmodule

// File: rtl/openram_scan_host.sv
// Host-side scan driver for the openram test chip: shifts a command packet in, pulses
// sram_load, waits, then shifts the captured chain back out as a parallel response.
module openram_scan_host
  import openram_tc_pkg::*;
#(
  parameter int unsigned PKT_W   = PKT_W_DEFAULT,
  parameter int unsigned DIV     = 2,
  parameter int unsigned LAT_CYC = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [PKT_W-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [PKT_W-1:0] rsp_data,
  output logic             scan_clk,
  output logic             scan_en,
  output logic             scan_in,
  output logic             sram_load,
  output logic             chip_csb,
  input  logic             scan_out
);

  localparam int unsigned BCW       = $clog2(PKT_W + 1);
  localparam int unsigned WCW       = (LAT_CYC > 0) ? $clog2(LAT_CYC + 1) : 1;
  localparam int unsigned WAIT_LAST = (LAT_CYC > 0) ? LAT_CYC - 1 : 0;
  localparam logic [BCW-1:0] BIT_END  = BCW'(PKT_W - 1);
  localparam logic [WCW-1:0] WAIT_END = WCW'(WAIT_LAST);

  scan_state_e    state, state_next;
  logic [BCW-1:0] bit_cnt;
  logic [WCW-1:0] wait_cnt;
  logic [PKT_W-1:0] shreg;
  logic run, tick_fall, tick_sample, accept, update;
  logic scan_en_next, scan_in_next, sram_load_next, chip_csb_next;

  assign rsp_valid = (state == DONE);
  assign cmd_ready = (state == IDLE) && !rsp_valid && rstn;
  assign accept    = cmd_valid && cmd_ready;
  assign run       = state inside {SHIFT_IN, LOAD, WAIT, SHIFT_OUT};
  // Pin outputs only move on accept or on a scan_clk falling edge.
  assign update    = accept || tick_fall;

  scan_clk_gen #(.DIV(DIV)) u_scan_clk_gen (
    .clk         (clk),
    .rstn        (rstn),
    .run         (run),
    .scan_clk    (scan_clk),
    .tick_fall   (tick_fall),
    .tick_sample (tick_sample)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (accept) state_next = SHIFT_IN;
      SHIFT_IN:  if (tick_fall && bit_cnt == BIT_END) state_next = LOAD;
      LOAD:      if (tick_fall) state_next = (LAT_CYC == 0) ? SHIFT_OUT : WAIT;
      WAIT:      if (tick_fall && wait_cnt == WAIT_END) state_next = SHIFT_OUT;
      SHIFT_OUT: if (tick_fall && bit_cnt == BIT_END) state_next = DONE;
      DONE:      if (rsp_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase

    scan_en_next   = state_next inside {SHIFT_IN, SHIFT_OUT};
    sram_load_next = (state_next == LOAD);
    chip_csb_next  = !(state_next inside {LOAD, WAIT});
    scan_in_next   = 1'b0;
    if (accept)                      scan_in_next = cmd_data[PKT_W-1];
    else if (state_next == SHIFT_IN) scan_in_next = shreg[PKT_W-2];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      shreg     <= '0;
      rsp_data  <= '0;
      scan_en   <= 1'b0;
      scan_in   <= 1'b0;
      sram_load <= 1'b0;
      chip_csb  <= 1'b1;
    end else begin
      state <= state_next;

      if (state_next != state) begin
        bit_cnt  <= '0;
        wait_cnt <= '0;
      end else if (tick_fall) begin
        if (state inside {SHIFT_IN, SHIFT_OUT}) bit_cnt <= bit_cnt + 1'b1;
        if (state == WAIT)                      wait_cnt <= wait_cnt + 1'b1;
      end

      if (accept)                              shreg <= cmd_data;
      else if (tick_fall && state == SHIFT_IN) shreg <= {shreg[PKT_W-2:0], 1'b0};

      // First bit received ends up in the MSB after PKT_W left shifts.
      if (tick_sample && state == SHIFT_OUT) rsp_data <= {rsp_data[PKT_W-2:0], scan_out};

      if (update) begin
        scan_en   <= scan_en_next;
        scan_in   <= scan_in_next;
        sram_load <= sram_load_next;
        chip_csb  <= chip_csb_next;
      end
    end
  end

endmodule

// File: tb/tb_openram_scan_host.sv
// Self-checking bench for openram_scan_host: two configurations, each with a behavioural
// chip model (scan chain that captures on scan_clk rise and launches on fall).
`timescale 1ns/1ps
module tb_openram_scan_host;

  localparam int W = 112;
  localparam logic [W-1:0] PAT  = {14{8'hA5}};
  localparam logic [W-1:0] SPEC = {56'hDEADBEEF_CAFE00, 56'h0123456789ABCD};

  typedef struct {
    logic [W-1:0] cmd;
    bit           load_en;
    logic [W-1:0] exp_rsp;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // Configuration A: DIV=2, LAT_CYC=2
  logic cmd_valid_a = 1'b0, rsp_ready_a = 1'b0;
  logic [W-1:0] cmd_data_a = '0;
  logic cmd_ready_a, rsp_valid_a, scan_clk_a, scan_en_a, scan_in_a, sram_load_a, chip_csb_a;
  logic [W-1:0] rsp_data_a;
  // Configuration B: DIV=1, LAT_CYC=0
  logic cmd_valid_b = 1'b0, rsp_ready_b = 1'b0;
  logic [W-1:0] cmd_data_b = '0;
  logic cmd_ready_b, rsp_valid_b, scan_clk_b, scan_en_b, scan_in_b, sram_load_b, chip_csb_b;
  logic [W-1:0] rsp_data_b;

  logic [W-1:0] chain_a = '0, chain_b = '0;
  logic out_a = 1'b0, out_b = 1'b0;
  bit chip_load_en = 1'b1;

  openram_scan_host #(.PKT_W(W), .DIV(2), .LAT_CYC(2)) dut_a (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_data(cmd_data_a), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_data(rsp_data_a), .scan_clk(scan_clk_a), .scan_en(scan_en_a), .scan_in(scan_in_a),
    .sram_load(sram_load_a), .chip_csb(chip_csb_a), .scan_out(out_a)
  );

  openram_scan_host #(.PKT_W(W), .DIV(1), .LAT_CYC(0)) dut_b (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_data(cmd_data_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_data(rsp_data_b), .scan_clk(scan_clk_b), .scan_en(scan_en_b), .scan_in(scan_in_b),
    .sram_load(sram_load_b), .chip_csb(chip_csb_b), .scan_out(out_b)
  );

  // Chip models: parallel load of PAT on sram_load when enabled, otherwise pure shift chain
  always @(posedge scan_clk_a)
    if (sram_load_a && chip_load_en) chain_a <= PAT;
    else if (scan_en_a)              chain_a <= {chain_a[W-2:0], scan_in_a};
  always @(negedge scan_clk_a) out_a <= chain_a[W-1];

  always @(posedge scan_clk_b)
    if (sram_load_b && chip_load_en) chain_b <= PAT;
    else if (scan_en_b)              chain_b <= {chain_b[W-2:0], scan_in_b};
  always @(negedge scan_clk_b) out_b <= chain_b[W-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_rsp(input logic [W-1:0] cmd, input bit load_en);
    return load_en ? PAT : cmd;
  endfunction

  // Every scan period is one chain bit in, the load, each wait slot, or one bit out.
  function automatic int model_lat(input int div, input int lat_cyc);
    return (2 * W + 1 + lat_cyc) * 2 * div;
  endfunction

  // Monitors: scan_in bits seen at scan_clk rises, sram_load width, scan_clk phase lengths
  logic cap_a[$];
  int load_cyc_a = 0;
  bit mon_en = 1'b1;
  int glitch_a = 0, glitch_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  int len_a = 2, len_b = 1;

  always @(posedge scan_clk_a) if (scan_en_a) cap_a.push_back(scan_in_a);

  always @(negedge clk) begin
    if (sram_load_a) load_cyc_a++;
    if (!mon_en) begin
      prev_a = scan_clk_a; len_a = 2;
      prev_b = scan_clk_b; len_b = 1;
    end else begin
      if (scan_clk_a !== prev_a) begin
        if (prev_a && len_a != 2) glitch_a++;
        if (!prev_a && len_a < 2) glitch_a++;
        prev_a = scan_clk_a; len_a = 1;
      end else len_a++;
      if (scan_clk_b !== prev_b) begin
        if (prev_b && len_b != 1) glitch_b++;
        if (!prev_b && len_b < 1) glitch_b++;
        prev_b = scan_clk_b; len_b = 1;
      end else len_b++;
    end
  end

  task automatic txn(input bit sel, input logic [W-1:0] cmd, output logic [W-1:0] rsp,
                     output int lat);
    int n;
    longint t0;
    @(negedge clk);
    n = 0;
    while (!(sel ? cmd_ready_b : cmd_ready_a) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("txn_cmd_ready", sel ? cmd_ready_b : cmd_ready_a, 1);
    if (sel) begin cmd_valid_b = 1'b1; cmd_data_b = cmd; end
    else     begin cmd_valid_a = 1'b1; cmd_data_a = cmd; end
    @(posedge clk);
    t0 = $time;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    n = 0;
    while (!(sel ? rsp_valid_b : rsp_valid_a) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    lat = int'(($time - t0 - 5) / 10);
    rsp = sel ? rsp_data_b : rsp_data_a;
    if (sel) rsp_ready_b = 1'b1; else rsp_ready_a = 1'b1;
    @(negedge clk);
    rsp_ready_a = 1'b0;
    rsp_ready_b = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] rsp, v, c1, c2;
    logic [127:0] r128;
    logic tail;
    int lat, n, bad, got;
    longint t_acc;
    longint rt[2];
    logic [W-1:0] rq[2];

    vecs[0] = '{cmd: SPEC,      load_en: 1'b1, exp_rsp: PAT};
    vecs[1] = '{cmd: SPEC,      load_en: 1'b0, exp_rsp: SPEC};
    vecs[2] = '{cmd: '1,        load_en: 1'b0, exp_rsp: '1};
    vecs[3] = '{cmd: '0,        load_en: 1'b1, exp_rsp: PAT};
    for (int i = 4; i < 6; i++) begin
      r128 = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].cmd     = r128[W-1:0];
      vecs[i].load_en = i[0];
      vecs[i].exp_rsp = model_rsp(vecs[i].cmd, vecs[i].load_en);
    end

    // Reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl_a", {cmd_ready_a, rsp_valid_a, scan_clk_a, scan_en_a, scan_in_a,
                           sram_load_a, chip_csb_a}, 7'b0000001);
    check("reset_ctrl_b", {cmd_ready_b, rsp_valid_b, scan_clk_b, scan_en_b, scan_in_b,
                           sram_load_b, chip_csb_b}, 7'b0000001);
    check("reset_rsp_data_a", rsp_data_a, '0);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_reset_a", cmd_ready_a, 1);

    // Table-driven transactions on configuration A
    for (int i = 0; i < 6; i++) begin
      chip_load_en = vecs[i].load_en;
      cap_a.delete();
      load_cyc_a = 0;
      txn(1'b0, vecs[i].cmd, rsp, lat);
      check($sformatf("vec%0d_rsp", i), rsp, vecs[i].exp_rsp);
      check($sformatf("vec%0d_latency", i), lat, model_lat(2, 2));
      check($sformatf("vec%0d_load_cycles", i), load_cyc_a, 4);
      check($sformatf("vec%0d_scan_rises", i), cap_a.size(), 2 * W);
      v = '0;
      tail = 1'b0;
      for (int k = 0; k < cap_a.size(); k++) begin
        if (k < W) v = {v[W-2:0], cap_a[k]};
        else       tail = tail | cap_a[k];
      end
      check($sformatf("vec%0d_scan_in_seq", i), v, vecs[i].cmd);
      check($sformatf("vec%0d_scan_in_out_phase", i), tail, 0);
    end

    // Randomized loopback/load on configuration B
    for (int i = 0; i < 3; i++) begin
      r128 = {$urandom, $urandom, $urandom, $urandom};
      chip_load_en = bit'($urandom_range(1, 0));
      txn(1'b1, r128[W-1:0], rsp, lat);
      check($sformatf("rand_b%0d_rsp", i), rsp, model_rsp(r128[W-1:0], chip_load_en));
      check($sformatf("rand_b%0d_latency", i), lat, model_lat(1, 0));
    end

    // Response back-pressure with cmd_valid held high throughout
    r128 = {$urandom, $urandom, $urandom, $urandom};
    c1 = SPEC;
    c2 = r128[W-1:0];
    chip_load_en = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b1;
    cmd_data_a = c1;
    n = 0;
    while (!rsp_valid_a && n < 5000) begin
      @(negedge clk);
      n++;
    end
    cmd_data_a = c2;
    chip_load_en = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid_a !== 1'b1 || cmd_ready_a !== 1'b0 || scan_clk_a !== 1'b0) bad++;
    end
    check("bp_hold", bad, 0);
    check("bp_rsp1", rsp_data_a, PAT);
    rsp_ready_a = 1'b1;
    @(negedge clk);
    rsp_ready_a = 1'b0;
    check("bp_after_handshake", {rsp_valid_a, cmd_ready_a, scan_en_a}, 3'b010);
    @(negedge clk);
    check("bp_second_accept", {cmd_ready_a, scan_en_a, scan_in_a}, {2'b01, c2[W-1]});
    cmd_valid_a = 1'b0;
    n = 0;
    while (!rsp_valid_a && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp2", rsp_data_a, c2);
    rsp_ready_a = 1'b1;
    @(negedge clk);
    rsp_ready_a = 1'b0;

    // Reset during SHIFT_IN at bit 50
    mon_en = 1'b0;
    chip_load_en = 1'b1;
    cap_a.delete();
    @(negedge clk);
    cmd_valid_a = 1'b1;
    cmd_data_a = c2;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    n = 0;
    while (cap_a.size() < 50 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    rstn = 1'b0;
    @(negedge clk);
    check("midreset_ctrl", {cmd_ready_a, rsp_valid_a, scan_clk_a, scan_en_a, scan_in_a,
                            sram_load_a, chip_csb_a}, 7'b0000001);
    check("midreset_rsp_data", rsp_data_a, '0);
    rstn = 1'b1;
    @(negedge clk);
    check("midreset_ready", cmd_ready_a, 1);
    mon_en = 1'b1;
    txn(1'b0, c1, rsp, lat);
    check("post_reset_rsp", rsp, PAT);
    check("post_reset_latency", lat, model_lat(2, 2));

    // Back-to-back on B with rsp_ready tied high, loopback data
    chip_load_en = 1'b0;
    rsp_ready_b = 1'b1;
    rq[0] = '0; rq[1] = '0;
    rt[0] = 0;  rt[1] = 0;
    @(negedge clk);
    cmd_valid_b = 1'b1;
    cmd_data_b = c1;
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    cmd_data_b = c2;
    got = 0;
    n = 0;
    while (got < 2 && n < 3000) begin
      @(negedge clk);
      n++;
      if (got == 1 && $time == rt[0] + 20) cmd_valid_b = 1'b0;
      if (rsp_valid_b) begin
        rq[got] = rsp_data_b;
        rt[got] = $time;
        got++;
      end
    end
    cmd_valid_b = 1'b0;
    rsp_ready_b = 1'b0;
    check("b2b_count", got, 2);
    check("b2b_rsp0", rq[0], c1);
    check("b2b_rsp1", rq[1], c2);
    check("b2b_latency0", int'((rt[0] - t_acc - 5) / 10), model_lat(1, 0));
    check("b2b_spacing", int'((rt[1] - rt[0]) / 10), model_lat(1, 0) + 2);

    repeat (4) @(negedge clk);
    check("scan_clk_phase_a", glitch_a, 0);
    check("scan_clk_phase_b", glitch_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
